// File: rtl/seg_scan_decoder_if.sv
// Scan-bus bundle between the display scan driver and the decoder/checker.
// Latency: none, wires only.
// Backpressure: none; the scan bus is free-running. SEG_DP_EN adds DP and DP_FLAGS.
interface seg_scan_decoder_if;
  logic [3:0]  AN;
  logic [6:0]  SEG;
  logic [15:0] DIGITS;
  logic [3:0]  BLANK;
  logic [1:0]  CUR_IDX;
  logic        FRAME_STB;
  logic        FRAME_VALID;
  logic        ORDER_ERR;
  logic        CODE_ERR;
  logic        ANODE_ERR;
`ifdef SEG_DP_EN
  logic        DP;
  logic [3:0]  DP_FLAGS;

  modport master (
    output AN, SEG, DP,
    input  DIGITS, BLANK, CUR_IDX, FRAME_STB, FRAME_VALID,
    input  ORDER_ERR, CODE_ERR, ANODE_ERR, DP_FLAGS
  );

  modport slave (
    input  AN, SEG, DP,
    output DIGITS, BLANK, CUR_IDX, FRAME_STB, FRAME_VALID,
    output ORDER_ERR, CODE_ERR, ANODE_ERR, DP_FLAGS
  );
`else
  modport master (
    output AN, SEG,
    input  DIGITS, BLANK, CUR_IDX, FRAME_STB, FRAME_VALID,
    input  ORDER_ERR, CODE_ERR, ANODE_ERR
  );

  modport slave (
    input  AN, SEG,
    output DIGITS, BLANK, CUR_IDX, FRAME_STB, FRAME_VALID,
    output ORDER_ERR, CODE_ERR, ANODE_ERR
  );
`endif
endinterface

// File: rtl/seg_scan_decoder.sv
// Deglitches a 4-digit multiplexed seven-segment scan bus, decodes each dwell to a nibble, checks scan order.
// Latency: a dwell applied before edge E0 and held updates outputs on edge E0+SETTLE_CYCLES+1 (SETTLE_CYCLES 1..15).
// Backpressure: none, passive observer. Define SEG_DP_EN to add decimal-point capture (DP in, DP_FLAGS out).
module seg_scan_decoder #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic               CLK,
  input logic               RST,
  seg_scan_decoder_if.slave bus
);

  // One bus sample; DP takes part in the stability compare when enabled.
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
`ifdef SEG_DP_EN
    logic       dp;
`endif
  } smp_t;

  typedef enum logic {SYNC, TRACK} state_t;

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

  smp_t       smp_now;
  smp_t       smp_q;
  logic       same;
  logic [3:0] stab_cnt;
  logic       cap_pend;

  logic       an_gap;
  logic       an_legal;
  logic [1:0] an_pos;
  logic [6:0] seg_on;
  logic       dec_ok;
  logic       dec_blank;
  logic [3:0] dec_nib;

  state_t      state_q,   state_d;
  logic [1:0]  nxt_pos_q, nxt_pos_d;
  logic [15:0] digits_q,  digits_d;
  logic [3:0]  blank_q,   blank_d;
  logic [1:0]  idx_q,     idx_d;
  logic        stb_q,     stb_d;
  logic        fv_q,      fv_d;
  logic        oe_q,      oe_d;
  logic        ce_q,      ce_d;
  logic        ae_q,      ae_d;
`ifdef SEG_DP_EN
  logic [3:0]  dpf_q,     dpf_d;
`endif

  // Pack the live bus into a sample word.
  always_comb begin
    smp_now     = '0;
    smp_now.an  = bus.AN;
    smp_now.seg = bus.SEG;
`ifdef SEG_DP_EN
    smp_now.dp  = bus.DP;
`endif
  end

  assign same = (smp_now == smp_q);

  // Input stage: sample every cycle (even in reset) and count identical samples.
  // cap_pend fires once per dwell, the cycle after the counter first reaches SETTLE;
  // the capture then acts on smp_q, which still holds the settled value.
  always_ff @(posedge CLK) begin
    smp_q <= smp_now;
    if (RST) begin
      stab_cnt <= 4'd0;
      cap_pend <= 1'b0;
    end else begin
      cap_pend <= same && (stab_cnt == (SETTLE - 4'd1));
      if (!same) begin
        stab_cnt <= 4'd0;
      end else if (stab_cnt != SETTLE) begin
        stab_cnt <= stab_cnt + 4'd1;
      end
    end
  end

  // Anode decode: exactly one low strobe is a legal position, all-high is the inter-digit gap.
  always_comb begin
    an_gap   = 1'b0;
    an_legal = 1'b1;
    an_pos   = 2'd0;
    case (smp_q.an)
      4'b0111: an_pos = 2'd0;
      4'b1011: an_pos = 2'd1;
      4'b1101: an_pos = 2'd2;
      4'b1110: an_pos = 2'd3;
      4'b1111: begin
        an_gap   = 1'b1;
        an_legal = 1'b0;
      end
      default: an_legal = 1'b0;
    endcase
  end

  assign seg_on = ~smp_q.seg;

  // Segment decode on the active-high gfedcba pattern; all-off is a blank digit.
  always_comb begin
    dec_ok    = 1'b1;
    dec_blank = 1'b0;
    dec_nib   = 4'h0;
    case (seg_on)
      7'h3F: dec_nib = 4'h0;
      7'h06: dec_nib = 4'h1;
      7'h5B: dec_nib = 4'h2;
      7'h4F: dec_nib = 4'h3;
      7'h66: dec_nib = 4'h4;
      7'h6D: dec_nib = 4'h5;
      7'h7D: dec_nib = 4'h6;
      7'h07: dec_nib = 4'h7;
      7'h7F: dec_nib = 4'h8;
      7'h6F: dec_nib = 4'h9;
      7'h77: dec_nib = 4'hA;
      7'h7C: dec_nib = 4'hB;
      7'h39: dec_nib = 4'hC;
      7'h5E: dec_nib = 4'hD;
      7'h79: dec_nib = 4'hE;
      7'h71: dec_nib = 4'hF;
      7'h00: dec_blank = 1'b1;
      default: dec_ok = 1'b0;
    endcase
  end

  // Next-state: digit storage, sticky flags and the SYNC/TRACK order checker.
  // An undecodable pattern still advances the order checker.
  always_comb begin
    state_d   = state_q;
    nxt_pos_d = nxt_pos_q;
    digits_d  = digits_q;
    blank_d   = blank_q;
    idx_d     = idx_q;
    stb_d     = 1'b0;
    fv_d      = fv_q;
    oe_d      = oe_q;
    ce_d      = ce_q;
    ae_d      = ae_q;
`ifdef SEG_DP_EN
    dpf_d     = dpf_q;
`endif
    if (cap_pend && !an_gap) begin
      if (!an_legal) begin
        ae_d = 1'b1;
      end else begin
        idx_d = an_pos;
`ifdef SEG_DP_EN
        dpf_d[an_pos] = ~smp_q.dp;
`endif
        if (dec_ok) begin
          digits_d[{an_pos, 2'b00} +: 4] = dec_nib;
          blank_d[an_pos]                = dec_blank;
        end else begin
          ce_d = 1'b1;
        end
        case (state_q)
          SYNC: begin
            if (an_pos == 2'd0) begin
              state_d   = TRACK;
              nxt_pos_d = 2'd1;
            end
          end
          TRACK: begin
            if (an_pos == nxt_pos_q) begin
              if (an_pos == 2'd3) begin
                stb_d     = 1'b1;
                fv_d      = 1'b1;
                nxt_pos_d = 2'd0;
              end else begin
                nxt_pos_d = nxt_pos_q + 2'd1;
              end
            end else begin
              oe_d = 1'b1;
              fv_d = 1'b0;
              if (an_pos == 2'd0) begin
                nxt_pos_d = 2'd1;
              end else begin
                state_d = SYNC;
              end
            end
          end
          default: state_d = SYNC;
        endcase
      end
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= SYNC;
      nxt_pos_q <= 2'd0;
      digits_q  <= 16'h0000;
      blank_q   <= 4'h0;
      idx_q     <= 2'd0;
      stb_q     <= 1'b0;
      fv_q      <= 1'b0;
      oe_q      <= 1'b0;
      ce_q      <= 1'b0;
      ae_q      <= 1'b0;
`ifdef SEG_DP_EN
      dpf_q     <= 4'h0;
`endif
    end else begin
      state_q   <= state_d;
      nxt_pos_q <= nxt_pos_d;
      digits_q  <= digits_d;
      blank_q   <= blank_d;
      idx_q     <= idx_d;
      stb_q     <= stb_d;
      fv_q      <= fv_d;
      oe_q      <= oe_d;
      ce_q      <= ce_d;
      ae_q      <= ae_d;
`ifdef SEG_DP_EN
      dpf_q     <= dpf_d;
`endif
    end
  end

  assign bus.DIGITS      = digits_q;
  assign bus.BLANK       = blank_q;
  assign bus.CUR_IDX     = idx_q;
  assign bus.FRAME_STB   = stb_q;
  assign bus.FRAME_VALID = fv_q;
  assign bus.ORDER_ERR   = oe_q;
  assign bus.CODE_ERR    = ce_q;
  assign bus.ANODE_ERR   = ae_q;
`ifdef SEG_DP_EN
  assign bus.DP_FLAGS    = dpf_q;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: scoreboard of expected output snapshots per dwell.
// Latency: captures expected SETTLE+2 edges after a dwell is applied.
// Backpressure: none on the DUT; the bench drives the scan bus freely.
`timescale 1ns/1ps
module tb_seg_scan_decoder;
  localparam int SETTLE = 2;
  localparam logic [6:0] SEG_ON [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  localparam logic [3:0] POS_AN [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  blank;
    logic [1:0]  idx;
    logic        fv;
    logic        oe;
    logic        ce;
    logic        ae;
    logic [3:0]  dp;
  } rec_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  seg_scan_decoder_if sif();
  seg_scan_decoder #(.SETTLE_CYCLES(SETTLE)) dut (.CLK(CLK), .RST(RST), .bus(sif));

  int checks = 0;
  int errors = 0;
  rec_t exp_q[$];

  // reference model state
  logic [15:0] m_digits;
  logic [3:0]  m_blank, m_dp;
  logic [1:0]  m_idx;
  logic        m_fv, m_oe, m_ce, m_ae, m_track;
  int          m_exp, m_stb;

  // frame strobe monitor
  int cyc = 0, cap_cyc = 0, last_stb_cyc = -1, stb_hi = 0, stb_pulses = 0;
  logic stb_prev = 1'b0;
  always @(posedge CLK) cyc++;
  always @(negedge CLK) begin
    if (sif.FRAME_STB === 1'b1) begin
      stb_hi++;
      last_stb_cyc = cyc;
      if (stb_prev !== 1'b1) stb_pulses++;
    end
    stb_prev = sif.FRAME_STB;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic logic [6:0] enc(input int k);
    return ~SEG_ON[k];
  endfunction

  function automatic rec_t dut_rec();
    rec_t r;
    r.digits = sif.DIGITS;
    r.blank  = sif.BLANK;
    r.idx    = sif.CUR_IDX;
    r.fv     = sif.FRAME_VALID;
    r.oe     = sif.ORDER_ERR;
    r.ce     = sif.CODE_ERR;
    r.ae     = sif.ANODE_ERR;
`ifdef SEG_DP_EN
    r.dp     = sif.DP_FLAGS;
`else
    r.dp     = 4'h0;
`endif
    return r;
  endfunction

  function automatic rec_t model_rec();
    rec_t r;
    r.digits = m_digits;
    r.blank  = m_blank;
    r.idx    = m_idx;
    r.fv     = m_fv;
    r.oe     = m_oe;
    r.ce     = m_ce;
    r.ae     = m_ae;
`ifdef SEG_DP_EN
    r.dp     = m_dp;
`else
    r.dp     = 4'h0;
`endif
    return r;
  endfunction

  task automatic model_reset();
    m_digits = '0; m_blank = '0; m_dp = '0; m_idx = '0;
    m_fv = 0; m_oe = 0; m_ce = 0; m_ae = 0; m_track = 0; m_exp = 0;
  endtask

  task automatic model_capture(input logic [3:0] an, input logic [6:0] seg, input logic dp);
    int p;
    int nib;
    logic [6:0] on;
    p = -2;
    for (int k = 0; k < 4; k++) if (an == POS_AN[k]) p = k;
    if (an == 4'b1111) return;
    if (p < 0) begin
      m_ae = 1'b1;
      return;
    end
    m_idx = 2'(p);
    m_dp[p] = ~dp;
    on = ~seg;
    nib = -1;
    for (int k = 0; k < 16; k++) if (on == SEG_ON[k]) nib = k;
    if (on == 7'h00) begin
      m_digits[p*4 +: 4] = 4'h0;
      m_blank[p] = 1'b1;
    end else if (nib >= 0) begin
      m_digits[p*4 +: 4] = 4'(nib);
      m_blank[p] = 1'b0;
    end else begin
      m_ce = 1'b1;
    end
    if (!m_track) begin
      if (p == 0) begin m_track = 1; m_exp = 1; end
    end else if (p == m_exp) begin
      if (p == 3) begin m_fv = 1; m_exp = 0; m_stb++; end
      else m_exp = m_exp + 1;
    end else begin
      m_oe = 1; m_fv = 0;
      if (p == 0) m_exp = 1;
      else m_track = 0;
    end
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input logic dp);
    sif.AN = an;
    sif.SEG = seg;
`ifdef SEG_DP_EN
    sif.DP = dp;
`endif
  endtask

  // Apply one dwell; push the expected post-dwell snapshot.
  task automatic dwell(input logic [3:0] an, input logic [6:0] seg, input logic dp, input int len);
    drive(an, seg, dp);
    if (len >= SETTLE + 2) model_capture(an, seg, dp);
    exp_q.push_back(model_rec());
    for (int i = 1; i <= len; i++) begin
      @(posedge CLK); #1;
      if (i == SETTLE + 2) cap_cyc = cyc;
    end
  endtask

  task automatic gap(input int len);
    drive(4'b1111, 7'h7F, 1'b1);
    repeat (len) begin @(posedge CLK); #1; end
  endtask

  task automatic test_reset();
    rec_t r;
    drive(4'b1111, 7'h7F, 1'b1);
    RST = 1'b1;
    repeat (3) begin @(posedge CLK); #1; end
    model_reset();
    r = dut_rec();
    checks++;
    if (r !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", r); end
    checks++;
    if (sif.FRAME_STB !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b expected 0", sif.FRAME_STB); end
    RST = 1'b0;
    gap(4);
    r = dut_rec();
    checks++;
    if (r !== '0) begin errors++; $display("FAIL idle_gap: got %h expected 0", r); end
  endtask

  task automatic test_clean_frame();
    rec_t r;
    int p0, s3;
    p0 = stb_pulses;
    s3 = 0;
    for (int i = 0; i < 4; i++) begin
      dwell(POS_AN[i], enc(i + 1), 1'b1, 4);
      if (i == 3) s3 = cap_cyc;
      gap(1);
      r = exp_q.pop_front();
      checks++;
      if (dut_rec() !== r) begin errors++; $display("FAIL clean_dwell%0d: got %h expected %h", i, dut_rec(), r); end
    end
    checks++;
    if (sif.DIGITS !== 16'h4321) begin errors++; $display("FAIL clean_digits: got %h expected 4321", sif.DIGITS); end
    checks++;
    if (stb_pulses - p0 !== 1) begin errors++; $display("FAIL clean_stb_count: got %0d expected 1", stb_pulses - p0); end
    checks++;
    if (last_stb_cyc !== s3) begin errors++; $display("FAIL clean_stb_cycle: got %0d expected %0d", last_stb_cyc, s3); end
    checks++;
    if ({sif.FRAME_VALID, sif.ORDER_ERR, sif.CODE_ERR, sif.ANODE_ERR} !== 4'b1000) begin
      errors++; $display("FAIL clean_flags: got %b expected 1000", {sif.FRAME_VALID, sif.ORDER_ERR, sif.CODE_ERR, sif.ANODE_ERR});
    end
  endtask

  task automatic test_glitch();
    rec_t r;
    logic [3:0] ans [5];
    int vals [5];
    int lens [5];
    ans = '{POS_AN[0], POS_AN[1], POS_AN[1], POS_AN[2], POS_AN[3]};
    vals = '{5, 9, 6, 7, 8};
    lens = '{4, 2, 4, 4, 4};
    for (int i = 0; i < 5; i++) begin
      dwell(ans[i], enc(vals[i]), 1'b1, lens[i]);
      gap(1);
      r = exp_q.pop_front();
      checks++;
      if (dut_rec() !== r) begin errors++; $display("FAIL glitch_dwell%0d: got %h expected %h", i, dut_rec(), r); end
      if (i == 1) begin
        checks++;
        if (sif.DIGITS !== 16'h4325) begin errors++; $display("FAIL glitch_ignored: got %h expected 4325", sif.DIGITS); end
      end
    end
    checks++;
    if (sif.DIGITS !== 16'h8765 || sif.ORDER_ERR !== 1'b0) begin
      errors++; $display("FAIL glitch_final: got digits %h oe %b expected 8765 0", sif.DIGITS, sif.ORDER_ERR);
    end
  endtask

  task automatic test_order_err();
    rec_t r;
    int p0;
    int seq [7];
    seq = '{0, 1, 3, 0, 1, 2, 3};
    p0 = stb_pulses;
    for (int i = 0; i < 7; i++) begin
      dwell(POS_AN[seq[i]], enc(i + 1), 1'b1, 4);
      gap(1);
      r = exp_q.pop_front();
      checks++;
      if (dut_rec() !== r) begin errors++; $display("FAIL order_dwell%0d: got %h expected %h", i, dut_rec(), r); end
      if (i == 2) begin
        checks++;
        if (sif.ORDER_ERR !== 1'b1 || sif.FRAME_VALID !== 1'b0 || stb_pulses != p0) begin
          errors++; $display("FAIL order_detect: got oe %b fv %b stb %0d expected 1 0 0", sif.ORDER_ERR, sif.FRAME_VALID, stb_pulses - p0);
        end
      end
    end
    checks++;
    if (stb_pulses - p0 !== 1 || sif.FRAME_VALID !== 1'b1 || sif.ORDER_ERR !== 1'b1) begin
      errors++; $display("FAIL order_recover: got stb %0d fv %b oe %b expected 1 1 1", stb_pulses - p0, sif.FRAME_VALID, sif.ORDER_ERR);
    end
    checks++;
    if (sif.DIGITS !== 16'h7654) begin errors++; $display("FAIL order_digits: got %h expected 7654", sif.DIGITS); end
  endtask

  task automatic test_code_blank();
    rec_t r;
    logic [6:0] segs [8];
    segs = '{enc(1), 7'h55, 7'h00, enc(4), enc(1), enc(5), 7'h7F, enc(4)};
    for (int i = 0; i < 8; i++) begin
      dwell(POS_AN[i % 4], segs[i], 1'b1, 4);
      gap(1);
      r = exp_q.pop_front();
      checks++;
      if (dut_rec() !== r) begin errors++; $display("FAIL code_dwell%0d: got %h expected %h", i, dut_rec(), r); end
      if (i == 3) begin
        checks++;
        if (sif.DIGITS !== 16'h4851 || sif.CODE_ERR !== 1'b1) begin
          errors++; $display("FAIL code_err: got digits %h ce %b expected 4851 1", sif.DIGITS, sif.CODE_ERR);
        end
      end
    end
    checks++;
    if (sif.BLANK !== 4'b0100 || sif.DIGITS !== 16'h4051) begin
      errors++; $display("FAIL blank: got blank %b digits %h expected 0100 4051", sif.BLANK, sif.DIGITS);
    end
  endtask

  task automatic test_back_to_back();
    rec_t r;
    int p0;
    p0 = stb_pulses;
    for (int i = 0; i < 4; i++) begin
      dwell(POS_AN[i], enc(9 + i), 1'b1, 4);
      r = exp_q.pop_front();
      checks++;
      if (dut_rec() !== r) begin errors++; $display("FAIL b2b_dwell%0d: got %h expected %h", i, dut_rec(), r); end
    end
    gap(1);
    checks++;
    if (sif.DIGITS !== 16'hCBA9 || sif.BLANK !== 4'b0000 || stb_pulses - p0 !== 1) begin
      errors++; $display("FAIL b2b_final: got digits %h blank %b stb %0d expected CBA9 0000 1", sif.DIGITS, sif.BLANK, stb_pulses - p0);
    end
    checks++;
    if (stb_hi !== stb_pulses || m_stb !== stb_pulses) begin
      errors++; $display("FAIL stb_width: got high %0d pulses %0d expected %0d", stb_hi, stb_pulses, m_stb);
    end
  endtask

`ifdef SEG_DP_EN
  task automatic test_dp();
    rec_t r;
    for (int i = 0; i < 4; i++) begin
      dwell(POS_AN[i], enc(i), (i == 3) ? 1'b0 : 1'b1, 4);
      gap(1);
      r = exp_q.pop_front();
      checks++;
      if (dut_rec() !== r) begin errors++; $display("FAIL dp_dwell%0d: got %h expected %h", i, dut_rec(), r); end
    end
    checks++;
    if (sif.DP_FLAGS !== 4'b1000) begin errors++; $display("FAIL dp_flags: got %b expected 1000", sif.DP_FLAGS); end
  endtask
`endif

  task automatic test_anode_fault();
    rec_t r;
    logic [15:0] d0;
    logic [1:0]  i0;
    d0 = sif.DIGITS;
    i0 = sif.CUR_IDX;
    dwell(4'b0011, enc(1), 1'b1, 5);
    gap(1);
    r = exp_q.pop_front();
    checks++;
    if (dut_rec() !== r) begin errors++; $display("FAIL anode_dwell: got %h expected %h", dut_rec(), r); end
    checks++;
    if (sif.ANODE_ERR !== 1'b1 || sif.DIGITS !== d0 || sif.CUR_IDX !== i0) begin
      errors++; $display("FAIL anode_err: got ae %b digits %h idx %0d expected 1 %h %0d", sif.ANODE_ERR, sif.DIGITS, sif.CUR_IDX, d0, i0);
    end
  endtask

  task automatic test_reset_mid_dwell();
    rec_t r;
    drive(POS_AN[0], enc(5), 1'b1);
    repeat (2) begin @(posedge CLK); #1; end
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    model_reset();
    checks++;
    if (dut_rec() !== '0 || sif.FRAME_STB !== 1'b0) begin
      errors++; $display("FAIL rst_mid_clear: got %h stb %b expected 0 0", dut_rec(), sif.FRAME_STB);
    end
    for (int i = 1; i <= 3; i++) begin
      @(posedge CLK); #1;
      if (i < 3) begin
        checks++;
        if (sif.DIGITS !== 16'h0000) begin errors++; $display("FAIL rst_mid_early%0d: got %h expected 0000", i, sif.DIGITS); end
      end
    end
    model_capture(POS_AN[0], enc(5), 1'b1);
    exp_q.push_back(model_rec());
    r = exp_q.pop_front();
    checks++;
    if (dut_rec() !== r) begin errors++; $display("FAIL rst_mid_recapture: got %h expected %h", dut_rec(), r); end
    checks++;
    if (sif.DIGITS !== 16'h0005) begin errors++; $display("FAIL rst_mid_digits: got %h expected 0005", sif.DIGITS); end
    gap(2);
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_glitch();
    test_order_err();
    test_code_blank();
    test_back_to_back();
`ifdef SEG_DP_EN
    test_dp();
`endif
    test_anode_fault();
    test_reset_mid_dwell();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
